avg_window_ctrl: RTL

AVG_WINDOW_CTRL -- requirements
Module: avg_window_ctrl

---
 rtl/avg_window_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/avg_window_ctrl.sv
// avg_window_ctrl
//   Sequences one averaging window at a time. Samples are accepted from an
//   upstream valid/ready source and forwarded to an external averager. The
//   averager's result is captured once its latency has elapsed. The averager
//   accumulator is then cleared before the controller returns to idle.
//
// Parameters
//   WIDTH  : sample / average width in bits
//   WINDOW : samples per averaging window (2..65535)
//   LAT    : averager latency, sample strobe to updated average (1..15)
//
// Ports
//   clk, rst               : rising-edge clock, asynchronous active-low reset
//   start, abort           : begin a window (idle only) / cancel a window
//   in_valid, in_data      : upstream sample
//   in_ready               : sample accepted when high together with in_valid
//   avg_sample(_ready)     : sample and one-cycle strobe to the averager
//   avg_clr                : averager accumulator clear
//   avg_in                 : averager result
//   result, result_valid   : captured window average and one-cycle strobe
//   busy                   : controller not idle
//   count                  : samples accepted in the current window
module avg_window_ctrl #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned WINDOW = 16,
  parameter int unsigned LAT    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] avg_sample,
  output logic             avg_sample_ready,
  output logic             avg_clr,
  input  logic [WIDTH-1:0] avg_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic [15:0]      count
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    CAPTURE,
    CLEAR
  } state_t;

  localparam logic [15:0] WIN_FULL = 16'(WINDOW);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
  localparam logic [3:0]  LAT_CNT  = 4'(LAT);

  state_t           state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic [3:0]       dly_q, dly_d;
  logic [WIDTH-1:0] smp_q, smp_d;
  logic             smp_rdy_q, smp_rdy_d;
  logic [WIDTH-1:0] result_q, result_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dly_d     = dly_q;
    smp_d     = smp_q;
    smp_rdy_d = 1'b0;
    result_d  = result_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          count_d = '0;
        end
      end
      FILL: begin
        if (in_valid) begin
          smp_d     = in_data;
          smp_rdy_d = 1'b1;
          if (count_q < WIN_FULL) count_d = count_q + 16'd1;
        end
        // The strobe for a sample accepted alongside abort is still issued;
        // only the transition is overridden.
        if (abort) begin
          state_d = CLEAR;
        end else if (in_valid && (count_q == WIN_LAST)) begin
          state_d = DRAIN;
          dly_d   = '0;
        end
      end
      DRAIN: begin
        // The strobe is seen by the averager one cycle after acceptance,
        // so capture happens LAT+1 edges after the last accept.
        if (abort) begin
          state_d = CLEAR;
        end else if (dly_q == LAT_CNT) begin
          state_d  = CAPTURE;
          result_d = avg_in;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      CAPTURE: state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == CLEAR) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      dly_q     <= '0;
      smp_q     <= '0;
      smp_rdy_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dly_q     <= dly_d;
      smp_q     <= smp_d;
      smp_rdy_q <= smp_rdy_d;
      result_q  <= result_d;
    end
  end

  assign in_ready         = (state_q == FILL);
  assign busy             = (state_q != IDLE);
  assign result_valid     = (state_q == CAPTURE);
  // Held in clear throughout reset so the averager starts every run empty.
  assign avg_clr          = (state_q == CLEAR) | ~rst;
  assign avg_sample       = smp_q;
  assign avg_sample_ready = smp_rdy_q;
  assign result           = result_q;
  assign count            = count_q;

endmodule
